// File: rtl/edge_pkg.sv
// Shared encodings and limits for the edge filter bank.
package edge_pkg;

  // Per-channel event select, two bits per channel on the mode bus
  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  // Supported parameter ranges
  localparam int N_CH_MIN  = 1;
  localparam int N_CH_MAX  = 32;
  localparam int SYNC_MIN  = 2;
  localparam int SYNC_MAX  = 4;
  localparam int FILT_MIN  = 1;
  localparam int FILT_MAX  = 255;
  localparam int CNT_W_MIN = 1;
  localparam int CNT_W_MAX = 16;

  // Filtered-edge flags of one channel
  typedef struct packed {
    logic level;
    logic rise;
    logic down;
  } edge_flags_t;

  // A registered pulse qualifies when its direction is enabled in the mode
  function automatic logic qualifies(input mode_e m, input edge_flags_t f);
    logic [1:0] mb;
    mb = m;
    return (f.rise & mb[0]) | (f.down & mb[1]);
  endfunction

endpackage

// File: rtl/edge_chan.sv
// One channel: synchroniser, debounce filter, edge pulses, sticky flag, counter.
module edge_chan
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic             level,
  output logic             rise,
  output logic             down,
  output logic             pend,
  output logic [CNT_W-1:0] cnt
);

  localparam int FW = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   s_q;
  logic [FW-1:0]          stab;
  logic                   accept;
  logic                   qual;
  edge_flags_t            flags;

  // Synchroniser chain; the last stage is the sampled value
  always_ff @(posedge clk) begin
    if (rst) sync <= '0;
    else     sync <= {sync[SYNC_STAGES-2:0], a};
  end

  assign s = sync[SYNC_STAGES-1];

  // The filter looks at a registered copy of the sample, so a change sampled
  // at edge 0 lands on level after SYNC_STAGES+FILT_LEN edges.
  assign accept = (s_q != level) && (stab == FW'(FILT_LEN - 1));

  // Stability counter, filtered level and one-cycle pulses aligned with level
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= 1'b0;
      stab  <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      down  <= 1'b0;
    end else begin
      s_q  <= s;
      rise <= accept & s_q;
      down <= accept & ~s_q;
      if (s_q == level) begin
        stab <= '0;
      end else if (accept) begin
        stab  <= '0;
        level <= s_q;
      end else begin
        stab <= stab + FW'(1);
      end
    end
  end

  assign flags = '{level: level, rise: rise, down: down};
  assign qual  = qualifies(mode_e'(mode), flags);

  // Sticky flag and saturating counter; an event coincident with clr survives
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= 1'b0;
      cnt  <= '0;
    end else if (qual) begin
      pend <= 1'b1;
      if (clr)       cnt <= CNT_W'(1);
      else if (~&cnt) cnt <= cnt + CNT_W'(1);
    end else if (clr) begin
      pend <= 1'b0;
      cnt  <= '0;
    end
  end

endmodule

// File: rtl/edge_filter_bank.sv
// Bank of independent debounced edge detectors with a shared interrupt.
module edge_filter_bank
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       a,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       level,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       down,
  output logic [N_CH-1:0]       pend,
  output logic [CNT_W*N_CH-1:0] cnt,
  output logic                  irq
);

  logic [N_CH-1:0][1:0]       mode_a;
  logic [N_CH-1:0][CNT_W-1:0] cnt_a;

  assign mode_a = mode;
  assign cnt    = cnt_a;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    edge_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk   (clk),
      .rst   (rst),
      .a     (a[i]),
      .mode  (mode_a[i]),
      .clr   (clr[i]),
      .level (level[i]),
      .rise  (rise[i]),
      .down  (down[i]),
      .pend  (pend[i]),
      .cnt   (cnt_a[i])
    );
  end

  // Interrupt follows the pend registers directly
  assign irq = |pend;

endmodule

// File: tb/tb_edge_filter_bank.sv
// Scoreboard bench: stimulus pushes expected pulse/flag snapshots, monitor pops on pulses.
module tb_edge_filter_bank;

  localparam int N  = 4;
  localparam int CW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    a;
  logic [2*N-1:0]  mode;
  logic [N-1:0]    clr;
  logic [N-1:0]    level, rise, down, pend;
  logic [CW*N-1:0] cnt;
  logic            irq;

  edge_filter_bank #(.N_CH(N), .SYNC_STAGES(2), .FILT_LEN(4), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .a(a), .mode(mode), .clr(clr),
    .level(level), .rise(rise), .down(down), .pend(pend), .cnt(cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    rise;
    logic [N-1:0]    down;
    logic [N-1:0]    level;
    logic [N-1:0]    pend;
    logic [CW*N-1:0] cnt;
    logic            irq;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // model state
  logic [N-1:0]    m_level = '0;
  logic [N-1:0]    m_pend  = '0;
  logic [CW*N-1:0] m_cnt   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model one input change (plus clr mask applied on the edge after the pulse)
  task automatic model(input logic [N-1:0] na, input logic [N-1:0] cm);
    exp_t e;
    logic r, d, qu;
    logic [CW-1:0] c;
    e.rise  = na & ~m_level;
    e.down  = ~na & m_level;
    e.level = na;
    for (int i = 0; i < N; i++) begin
      r  = e.rise[i];
      d  = e.down[i];
      qu = (r & mode[2*i]) | (d & mode[2*i+1]);
      c  = m_cnt[CW*i +: CW];
      if (qu) begin
        m_pend[i] = 1'b1;
        if (cm[i])       c = 1;
        else if (c != 3) c = c + 1;
      end else if (cm[i]) begin
        m_pend[i] = 1'b0;
        c = 0;
      end
      m_cnt[CW*i +: CW] = c;
    end
    m_level = na;
    e.pend = m_pend;
    e.cnt  = m_cnt;
    e.irq  = |m_pend;
    if ((e.rise | e.down) != '0) q.push_back(e);
  endtask

  // Drive a new input vector and walk it through the filter latency
  task automatic apply(input logic [N-1:0] na, input logic [N-1:0] cm);
    logic [N-1:0] old;
    old = m_level;
    model(na, cm);
    @(negedge clk); a = na;
    repeat (6) @(negedge clk);
    chk("level_before_latency", 32'(level), 32'(old));
    @(negedge clk);
    chk("level_at_latency", 32'(level), 32'(na));
    clr = cm;
    @(negedge clk); clr = '0;
    repeat (4) @(negedge clk);
    chk("pend_settled", 32'(pend), 32'(m_pend));
    chk("cnt_settled", 32'(cnt), 32'(m_cnt));
  endtask

  // Monitor: every pulse cycle must match the head of the queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (rise | down) != '0) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_pulse: rise=%b down=%b with nothing expected at %0t", rise, down, $time);
        end else begin
          e = q.pop_front();
          chk("mon_rise",  32'(rise),  32'(e.rise));
          chk("mon_down",  32'(down),  32'(e.down));
          chk("mon_level", 32'(level), 32'(e.level));
          @(negedge clk);
          chk("mon_rise_gone", 32'(rise | down), 32'(0));
          chk("mon_pend", 32'(pend), 32'(e.pend));
          chk("mon_cnt",  32'(cnt),  32'(e.cnt));
          chk("mon_irq",  32'(irq),  32'(e.irq));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; a = '0; clr = '0;
    mode = {2'b11, 2'b10, 2'b11, 2'b01};
    repeat (3) @(negedge clk);
    chk("rst_level", 32'(level), 32'(0));
    chk("rst_pulses", 32'(rise | down), 32'(0));
    chk("rst_pend", 32'(pend), 32'(0));
    chk("rst_cnt", 32'(cnt), 32'(0));
    chk("rst_irq", 32'(irq), 32'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // ch0 rise, mode 01
    apply(4'b0001, 4'b0000);
    chk("ch0_cnt_is_1", 32'(cnt[1:0]), 32'(1));

    // 3-cycle glitch on ch1 is filtered
    @(negedge clk); a = 4'b0011;
    repeat (3) @(negedge clk); a = 4'b0001;
    repeat (12) @(negedge clk);
    chk("glitch_level", 32'(level), 32'(4'b0001));
    chk("glitch_pend", 32'(pend), 32'(4'b0001));

    // ch2 mode 10: rise ignored, fall counted
    apply(4'b0101, 4'b0000);
    apply(4'b0001, 4'b0000);
    chk("ch2_cnt_is_1", 32'(cnt[5:4]), 32'(1));
    chk("ch2_irq", 32'(irq), 32'(1));

    // ch3 saturation at 3, then clr coincident with event
    apply(4'b1001, 4'b0000);
    apply(4'b0001, 4'b0000);
    apply(4'b1001, 4'b0000);
    chk("ch3_sat_3", 32'(cnt[7:6]), 32'(3));
    apply(4'b0001, 4'b0000);
    apply(4'b1001, 4'b0000);
    chk("ch3_sat_stays", 32'(cnt[7:6]), 32'(3));
    apply(4'b0001, 4'b1000);
    chk("ch3_clr_with_event_cnt", 32'(cnt[7:6]), 32'(1));
    chk("ch3_clr_with_event_pend", 32'(pend[3]), 32'(1));

    // clr alone on ch0
    apply(4'b0001, 4'b0001);
    chk("ch0_clr_pend", 32'(pend[0]), 32'(0));
    chk("ch0_clr_cnt", 32'(cnt[1:0]), 32'(0));

    // ch0 switched off: fall not recorded
    mode[1:0] = 2'b00;
    apply(4'b0000, 4'b0000);
    chk("ch0_off_pend", 32'(pend[0]), 32'(0));

    // simultaneous rise on all channels
    apply(4'b1111, 4'b0000);
    chk("all_level", 32'(level), 32'(4'b1111));

    // reset mid-filter aborts ch0 fall; start-up rises follow from release
    @(negedge clk); a = 4'b1110;
    repeat (3) @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("midrst_level", 32'(level), 32'(0));
    chk("midrst_pend", 32'(pend), 32'(0));
    chk("midrst_cnt", 32'(cnt), 32'(0));
    chk("midrst_irq", 32'(irq), 32'(0));
    rst = 1'b0;
    m_level = '0; m_pend = '0; m_cnt = '0;
    model(4'b1110, 4'b0000);
    repeat (6) @(negedge clk);
    chk("startup_not_early", 32'(level), 32'(0));
    @(negedge clk);
    chk("startup_level", 32'(level), 32'(4'b1110));
    repeat (5) @(negedge clk);
    chk("startup_pend", 32'(pend), 32'(4'b1010));

    repeat (4) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
